// File: rtl/rob_pkg.sv
// Shared types for the read-response ordering path: the R beat layout, the
// burst-arbiter state encoding and a round-robin pointer helper.
package rob_pkg;

    localparam int ROB_ID_WIDTH   = 4;
    localparam int ROB_DATA_WIDTH = 64;
    localparam int ROB_RESP_WIDTH = 2;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0]   id;
        logic [ROB_DATA_WIDTH-1:0] data;
        logic [ROB_RESP_WIDTH-1:0] resp;
        logic                      last;
    } r_beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index of the source that follows idx in round-robin order.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/r_if.sv
// AXI R-channel beat bundle with a valid/ready handshake.
interface r_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender (
        output valid,
        output id,
        output data,
        output resp,
        output last,
        input  ready
    );

    modport receiver (
        input  valid,
        input  id,
        input  data,
        input  resp,
        input  last,
        output ready
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: the first set request at or after
// ptr (wrapping) wins; returns it as one-hot and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // cand[k] is the source visited k-th when the search starts at ptr.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_off
            logic [IDX_W:0] sum;
            assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                     : sum[IDX_W-1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

    assign any   = |req;
    assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/r_burst_arbiter.sv
// Burst-locked round-robin arbiter sharing one R path among NUM_SRC beat
// sources, with a single registered output stage at full throughput.
module r_burst_arbiter
    import rob_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]      src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
    input  logic [NUM_SRC*RESP_WIDTH-1:0]    src_resp,
    input  logic [NUM_SRC-1:0]               src_last,
    r_if.sender                              r_out,
    output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
    output logic                             burst_active
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } beat_t;

    arb_state_t       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] grant_reg;
    logic             burst_reg;
    logic             out_valid_reg;
    beat_t            out_beat_reg;

    beat_t            src_beat [NUM_SRC];
    logic [NUM_SRC-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             can_load;
    logic             accept;
    logic [IDX_W-1:0] sel_idx;
    beat_t            sel_beat;
    logic [IDX_W-1:0] ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_beat[gi] = {src_id[gi*ID_WIDTH +: ID_WIDTH],
                                   src_data[gi*DATA_WIDTH +: DATA_WIDTH],
                                   src_resp[gi*RESP_WIDTH +: RESP_WIDTH],
                                   src_last[gi]};
        end
    endgenerate

    rr_pick #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (src_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign can_load = ~out_valid_reg | r_out.ready;

    // While locked, only the granted source is offered the slot; otherwise the
    // round-robin winner is. Downstream backpressure blocks everyone at once.
    always_comb begin
        src_ready = '0;
        if (rst) begin
            src_ready = '0;
        end else if (state_reg == BURST) begin
            src_ready[grant_reg] = can_load;
        end else if (pick_any && can_load) begin
            src_ready = pick_grant;
        end
    end

    assign accept   = |(src_valid & src_ready);
    assign sel_idx  = (state_reg == BURST) ? grant_reg : pick_idx;
    assign sel_beat = src_beat[sel_idx];
    assign ptr_next = IDX_W'(rr_next(int'(sel_idx), NUM_SRC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            burst_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_beat_reg  <= '0;
        end else begin
            if (can_load) begin
                out_valid_reg <= accept;
                if (accept) begin
                    out_beat_reg <= sel_beat;
                end
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (sel_beat.last) begin
                            ptr_reg <= ptr_next;
                        end else begin
                            state_reg <= BURST;
                            grant_reg <= pick_idx;
                            burst_reg <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (accept && sel_beat.last) begin
                        state_reg <= IDLE;
                        burst_reg <= 1'b0;
                        ptr_reg   <= ptr_next;
                    end
                end
            endcase
        end
    end

    assign r_out.valid  = out_valid_reg;
    assign r_out.id     = out_beat_reg.id;
    assign r_out.data   = out_beat_reg.data;
    assign r_out.resp   = out_beat_reg.resp;
    assign r_out.last   = out_beat_reg.last;
    assign grant_idx    = grant_reg;
    assign burst_active = burst_reg;

endmodule

// File: tb/tb_r_burst_arbiter.sv
// Randomized bench for r_burst_arbiter: a per-cycle reference of the arbitration
// rules feeds an expected-beat queue that an independent output monitor drains.
module tb_r_burst_arbiter;
    import rob_pkg::*;

    localparam int N  = 4;
    localparam int IW = ROB_ID_WIDTH;
    localparam int DW = ROB_DATA_WIDTH;
    localparam int RW = ROB_RESP_WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N*IW-1:0]   src_id;
    logic [N*DW-1:0]   src_data;
    logic [N*RW-1:0]   src_resp;
    logic [N-1:0]      src_last;
    logic [1:0]        grant_idx;
    logic              burst_active;

    r_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) rif ();

    r_burst_arbiter #(
        .NUM_SRC    (N),
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .RESP_WIDTH (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_id       (src_id),
        .src_data     (src_data),
        .src_resp     (src_resp),
        .src_last     (src_last),
        .r_out        (rif),
        .grant_idx    (grant_idx),
        .burst_active (burst_active)
    );

    always #5 clk = ~clk;

    r_beat_t src_q [N][$];
    r_beat_t exp_q [$];
    int      tests = 0;
    int      fails = 0;
    int      seq   = 0;
    int      ptr_m;
    int      locked_m;
    bit      hold_m;
    bit      mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        ptr_m    = 0;
        locked_m = -1;
        hold_m   = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic add_burst(input int s, input int len);
        r_beat_t b;
        for (int k = 0; k < len; k++) begin
            b.id   = IW'($urandom_range(0, (1 << IW) - 1));
            b.data = (64'(s) << 56) | (64'(seq) << 8) | 64'(k);
            b.resp = RW'($urandom_range(0, (1 << RW) - 1));
            b.last = (k == len - 1);
            seq++;
            src_q[s].push_back(b);
        end
    endtask

    // One clock: drive sources and downstream ready, then apply the rules:
    // a locked source owns the slot; otherwise the first valid source from ptr.
    task automatic step(input int vpct, input int rpct);
        logic [N-1:0] er;
        int           w;
        int           a;
        int           c;
        bit           can_load;
        r_beat_t      b;
        @(negedge clk);
        rif.ready = ($urandom_range(0, 99) < rpct);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                src_valid[i] = ($urandom_range(0, 99) < vpct);
            end else begin
                b = '0;
                src_valid[i] = 1'b0;
            end
            src_id[i*IW +: IW]   = b.id;
            src_data[i*DW +: DW] = b.data;
            src_resp[i*RW +: RW] = b.resp;
            src_last[i]          = b.last;
        end
        #1;
        can_load = !hold_m || rif.ready;
        er = '0;
        w  = -1;
        if (locked_m >= 0) begin
            er[locked_m] = can_load;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (w < 0 && src_valid[c]) w = c;
            end
            if (w >= 0 && can_load) er[w] = 1'b1;
        end
        check("src_ready", 64'(src_ready), 64'(er));
        check("r_out_valid", 64'(rif.valid), 64'(hold_m));
        check("burst_active", 64'(burst_active), 64'(locked_m >= 0));
        if (locked_m >= 0) check("grant_idx", 64'(grant_idx), 64'(locked_m));
        a = -1;
        for (int i = 0; i < N; i++) if (src_valid[i] && er[i]) a = i;
        if (a >= 0) begin
            b = src_q[a].pop_front();
            exp_q.push_back(b);
            hold_m = 1'b1;
            if (b.last) begin
                locked_m = -1;
                ptr_m    = (a + 1) % N;
            end else begin
                locked_m = a;
            end
        end else if (can_load) begin
            hold_m = 1'b0;
        end
    endtask

    function automatic int busy();
        int n = exp_q.size() + int'(hold_m);
        for (int i = 0; i < N; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic run_phase(input string name, input int vpct, input int rpct);
        int cyc = 0;
        while (busy() != 0 && cyc < 3000) begin
            step(vpct, rpct);
            cyc++;
        end
        #2;
        check({name, "_drained"}, 64'(busy()), 64'd0);
    endtask

    // Output monitor: every beat taken downstream must be the next expected one.
    initial begin
        r_beat_t got;
        r_beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rif.valid && rif.ready) begin
                got = {rif.id, rif.data, rif.resp, rif.last};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got data=%0h id=%0h none expected (t=%0t)",
                             got.data, got.id, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL beat: got id=%0h data=%0h resp=%0h last=%0b expected id=%0h data=%0h resp=%0h last=%0b (t=%0t)",
                                 got.id, got.data, got.resp, got.last,
                                 e.id, e.data, e.resp, e.last, $time);
                    end
                end
            end
        end
    end

    initial begin
        int vp [4] = '{100, 70, 100, 60};
        int rp [4] = '{100, 100, 50, 70};
        int cyc;
        rst = 1'b0;
        src_valid = '0; src_id = '0; src_data = '0; src_resp = '0; src_last = '0;
        rif.ready = 1'b0;
        reset_model();
        #1 rst = 1'b1;
        #1;
        check("reset_valid", 64'(rif.valid), 64'd0);
        check("reset_src_ready", 64'(src_ready), 64'd0);
        check("reset_burst_active", 64'(burst_active), 64'd0);
        check("reset_grant_idx", 64'(grant_idx), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        add_burst(1, 1); add_burst(2, 1);
        run_phase("singles_1_2", 100, 100);
        add_burst(0, 4); add_burst(3, 2);
        run_phase("burst_lock", 100, 100);
        for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_burst(s, 1);
        run_phase("rr_singles", 100, 100);

        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < N; s++)
                for (int k = 0; k < 5; k++) add_burst(s, $urandom_range(1, 4));
            run_phase($sformatf("random_%0d", p), vp[p], rp[p]);
        end

        // Reset while source 0 is two beats into a four-beat burst.
        add_burst(0, 4);
        cyc = 0;
        while (src_q[0].size() > 2 && cyc < 50) begin
            step(100, 100);
            cyc++;
        end
        check("pre_reset_locked", 64'(burst_active), 64'd1);
        @(negedge clk);
        #3 rst = 1'b1;
        mon_en = 1'b0;
        #1;
        check("midreset_valid", 64'(rif.valid), 64'd0);
        check("midreset_burst_active", 64'(burst_active), 64'd0);
        check("midreset_src_ready", 64'(src_ready), 64'd0);
        check("midreset_grant_idx", 64'(grant_idx), 64'd0);
        @(negedge clk);
        src_valid = '0;
        rst = 1'b0;
        reset_model();
        mon_en = 1'b1;

        add_burst(3, 1); add_burst(1, 1); add_burst(2, 3);
        run_phase("post_reset", 100, 100);
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 4; k++) add_burst(s, $urandom_range(1, 4));
        run_phase("final_random", 80, 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
